irq_controller: RTL
===================

IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 Parameter NSRC, default 8, number of interrupt sources (1..31).
REQ-002 Parameter BASE, default 32'h0000_2000, byte base address of the register window.
REQ-003 clk  input  1  single system clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 irq_src  input  NSRC  level inputs from peripherals (GEMM done, timer, ...), synchronous to clk.
REQ-006 addr  input  32  bus byte address.
REQ-007 wdata  input  32  bus write data.
REQ-008 wr_en  input  1  one-cycle bus write strobe.
REQ-009 rd_en  input  1  one-cycle bus read strobe.
REQ-010 rdata  output  32  read data, registered.
REQ-011 rvalid  output  1  high exactly one cycle after an accepted rd_en.
REQ-012 interupt  output  1  machine external interrupt line, driven into the core CSR unit (mip bit 11).

Function
REQ-013 Register map (offset from BASE): 0x0 PENDING (RO), 0x4 ENABLE (RW, bits NSRC-1:0), 0x8 CLAIM (read) / COMPLETE (write); other offsets read 0 and ignore writes.
REQ-014 Access accepted only when addr[31:4]==BASE[31:4]; wr_en and rd_en never asserted together (bench enforces).
REQ-015 Edge capture: prev_src register; pending[i] set in the cycle after irq_src[i] rises (0->1).
REQ-016 Claim id = 1 + lowest index i with pending[i]&enable[i]; 0 if none.
REQ-017 FSM states IDLE, ASSERT, SERVICE; interupt is registered and high only in ASSERT.
REQ-018 IDLE -> ASSERT when claim id != 0; ASSERT -> IDLE when claim id becomes 0 (e.g. ENABLE cleared) without a claim.
REQ-019 CLAIM read in ASSERT: rdata = claim id, clears that pending bit, latches in_service id, ASSERT -> SERVICE.
REQ-020 CLAIM read in IDLE or SERVICE: rdata = 0, no state change.
REQ-021 COMPLETE write in SERVICE with wdata[4:0]==in_service: in_service <- 0, SERVICE -> IDLE; mismatching id ignored.
REQ-022 COMPLETE write outside SERVICE ignored.
REQ-023 Same-cycle new edge on source i and claim of source i: pending[i] stays 1 (set wins).
REQ-024 Edges arriving in SERVICE accumulate in pending; no nesting; interupt reasserts the cycle after return to IDLE if any enabled pending.
REQ-025 A source's repeat edges while pending are merged (one claim).
REQ-026 Read latency 1 cycle; rdata holds its last value when rvalid low.

Reset
REQ-027 On reset: pending=0, enable=0, prev_src=0, in_service=0, state=IDLE, interupt=0, rdata=0, rvalid=0.
REQ-028 Reset mid-SERVICE or mid-read aborts: state IDLE, no rvalid the following cycle.
REQ-029 prev_src reloads from 0, so a source held high through reset sets pending one cycle after reset deasserts.

Structure
REQ-030 Shared package irq_pkg holds register offset constants, the irq_state_e enum (IDLE, ASSERT, SERVICE) and NSRC default.
REQ-031 One sub-module irq_prio_enc: combinational lowest-index priority encoder returning id (0 = none).
REQ-032 Total RTL 150-300 lines; no latches; all outputs driven from flops.

Verification
REQ-033 Reset, ENABLE=0x01, pulse irq_src[0] -> interupt high 2 cycles after edge; CLAIM read returns 1; interupt low next cycle.
REQ-034 ENABLE=0xFF, raise src 5 and 2 same cycle -> CLAIM returns 3; COMPLETE 3 -> interupt reasserts; CLAIM returns 6.
REQ-035 In SERVICE (id 1) write COMPLETE 2 -> ignored, state stays SERVICE; COMPLETE 1 -> IDLE.
REQ-036 Src 0 edge with ENABLE=0 -> PENDING reads 0x01, interupt stays 0; write ENABLE=0x01 -> interupt high.
REQ-037 Edge on src 0 in the same cycle as its claim -> PENDING still 0x01 after claim; after COMPLETE, interupt reasserts.
REQ-038 Assert reset while in SERVICE with pending 0x04 -> all registers 0, interupt 0, CLAIM returns 0.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller.
package irq_pkg;

    localparam int unsigned NSRC_DEFAULT = 8;
    localparam int unsigned ID_W         = 5;

    // Register offsets within the 16-byte window
    localparam logic [3:0] OFF_PENDING = 4'h0;
    localparam logic [3:0] OFF_ENABLE  = 4'h4;
    localparam logic [3:0] OFF_CLAIM   = 4'h8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index priority encoder; id_c = index+1 of the lowest set request, 0 when none.
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int unsigned NSRC = NSRC_DEFAULT
) (
    input  logic [NSRC-1:0] req,
    output logic [ID_W-1:0] id_c
);

    // Scan from the top so the lowest set index wins
    always_comb begin
        id_c = '0;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (req[i]) begin
                id_c = ID_W'(i + 1);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Edge-capturing interrupt controller with claim/complete handshake over a small register window.
module irq_controller
    import irq_pkg::*;
#(
    parameter int unsigned NSRC = NSRC_DEFAULT,
    parameter logic [31:0] BASE = 32'h0000_2000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_src,
    input  logic [31:0]     addr,
    input  logic [31:0]     wdata,
    input  logic            wr_en,
    input  logic            rd_en,
    output logic [31:0]     rdata,
    output logic            rvalid,
    output logic            interupt
);

    irq_state_e      state_q, state_d;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] enable_q, enable_d;
    logic [NSRC-1:0] prev_src_q, prev_src_d;
    logic [ID_W-1:0] in_service_q, in_service_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            rvalid_q, rvalid_d;
    logic            interupt_q, interupt_d;

    logic            hit;
    logic [3:0]      offset;
    logic            rd_acc;
    logic            wr_acc;
    logic            claim_rd;
    logic            complete_wr;
    logic            enable_wr;
    logic            take;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] clr_mask;
    logic [ID_W-1:0] claim_id_c;
    logic            unused_wdata;

    // Bus decode
    assign hit         = (addr[31:4] == BASE[31:4]);
    assign offset      = addr[3:0];
    assign rd_acc      = rd_en & hit;
    assign wr_acc      = wr_en & hit;
    assign claim_rd    = rd_acc & (offset == OFF_CLAIM);
    assign complete_wr = wr_acc & (offset == OFF_CLAIM);
    assign enable_wr   = wr_acc & (offset == OFF_ENABLE);

    // Only the low bits of wdata carry meaning for any register
    assign unused_wdata = ^wdata;

    irq_prio_enc #(
        .NSRC (NSRC)
    ) u_prio_enc (
        .req  (pending_q & enable_q),
        .id_c (claim_id_c)
    );

    // Handshake FSM: next state, claim/complete bookkeeping, interrupt line
    always_comb begin
        state_d      = state_q;
        in_service_d = in_service_q;
        take         = 1'b0;

        case (state_q)
            IDLE: begin
                if (claim_id_c != '0) begin
                    state_d = ASSERT;
                end
            end
            ASSERT: begin
                if (claim_rd) begin
                    if (claim_id_c != '0) begin
                        take         = 1'b1;
                        in_service_d = claim_id_c;
                        state_d      = SERVICE;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (claim_id_c == '0) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (complete_wr && (wdata[ID_W-1:0] == in_service_q)) begin
                    in_service_d = '0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        interupt_d = (state_d == ASSERT);
    end

    // Pending/enable update; a fresh rising edge wins over a same-cycle claim clear
    always_comb begin
        rise       = irq_src & ~prev_src_q;
        prev_src_d = irq_src;
        for (int unsigned i = 0; i < NSRC; i++) begin
            clr_mask[i] = take && (claim_id_c == ID_W'(i + 1));
        end
        pending_d = (pending_q & ~clr_mask) | rise;
        enable_d  = enable_wr ? wdata[NSRC-1:0] : enable_q;
    end

    // Read path; rdata holds between reads
    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = rd_acc;
        if (rd_acc) begin
            case (offset)
                OFF_PENDING: rdata_d = 32'(pending_q);
                OFF_ENABLE:  rdata_d = 32'(enable_q);
                OFF_CLAIM:   rdata_d = (state_q == ASSERT) ? 32'(claim_id_c) : 32'h0;
                default:     rdata_d = 32'h0;
            endcase
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            enable_q     <= '0;
            prev_src_q   <= '0;
            in_service_q <= '0;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
            interupt_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            enable_q     <= enable_d;
            prev_src_q   <= prev_src_d;
            in_service_q <= in_service_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
            interupt_q   <= interupt_d;
        end
    end

    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;
    assign interupt = interupt_q;

endmodule
